// File: rtl/hazard_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sb_pkg
//  Purpose  : Shared pipeline defines and helpers for the hazard scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_sb_pkg;

    // Equivalents of the pipeline defines RegAddrBus, NOPRegAddr, BblEnable and BblDisable.
    localparam int   c_reg_addr_bus_w = 5;
    localparam int   c_nop_reg_addr   = 0;
    localparam logic c_bbl_enable     = 1'b1;
    localparam logic c_bbl_disable    = 1'b0;

    function automatic int lat_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_match.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sb_match
//  Purpose  : Youngest-first match of one read operand against the window.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_sb_match
    import hazard_sb_pkg::*;
#(
    parameter int REG_AW = c_reg_addr_bus_w,
    parameter int DEPTH  = 3,
    parameter int LAT_W  = 2
) (
    input  logic                    rd_en,
    input  logic [REG_AW-1:0]       rd_addr,
    input  logic [DEPTH-1:0]        win_vld,
    input  logic [DEPTH*REG_AW-1:0] win_addr,
    input  logic [DEPTH*LAT_W-1:0]  win_rem,
    output logic                    hit,
    output logic                    hit_ready
);

    // Walk oldest to youngest so the youngest matching entry has the last word.
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (win_vld[i] && (win_addr[i*REG_AW +: REG_AW] == rd_addr)) begin
                hit       = 1'b1;
                hit_ready = (win_rem[i*LAT_W +: LAT_W] == '0);
            end
        end
        if (!rd_en || (rd_addr == REG_AW'(c_nop_reg_addr))) begin
            hit       = 1'b0;
            hit_ready = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sb
//  Purpose  : In-flight destination window and bubble request for decode.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_sb
    import hazard_sb_pkg::*;
#(
    parameter int  NUM_RD = 2,
    parameter int  REG_AW = c_reg_addr_bus_w,
    parameter int  DEPTH  = 3,
    parameter int  FWD_EN = 1,
    parameter int  CNT_W  = 16,
    localparam int LAT_W  = lat_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stop,
    input  logic                     flush,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic                     wr_en,
    input  logic [REG_AW-1:0]        wr_addr,
    input  logic [LAT_W-1:0]         wr_lat,
    output logic                     bbl,
    output logic [NUM_RD-1:0]        hz_port,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic                    r_vld  [DEPTH];
    logic [REG_AW-1:0]       r_addr [DEPTH];
    logic [LAT_W-1:0]        r_rem  [DEPTH];
    logic [CNT_W-1:0]        r_stall_cnt;

    logic [DEPTH-1:0]        w_win_vld;
    logic [DEPTH*REG_AW-1:0] w_win_addr;
    logic [DEPTH*LAT_W-1:0]  w_win_rem;
    logic                    w_issue;
    logic [LAT_W-1:0]        w_lat_clamped;
    logic [NUM_RD-1:0]       w_hit;
    logic [NUM_RD-1:0]       w_hit_ready;

    assign w_issue       = wr_en && (bbl == c_bbl_disable) && (wr_addr != REG_AW'(c_nop_reg_addr));
    assign w_lat_clamped = ({1'b0, wr_lat} > (LAT_W+1)'(DEPTH)) ? LAT_W'(DEPTH) : wr_lat;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_win
            if (i == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_vld[0]  <= 1'b0;
                        r_addr[0] <= '0;
                        r_rem[0]  <= '0;
                    end else if (flush) begin
                        r_vld[0]  <= 1'b0;
                    end else if (!stop) begin
                        r_vld[0]  <= w_issue;
                        r_addr[0] <= wr_addr;
                        r_rem[0]  <= w_lat_clamped;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_vld[i]  <= 1'b0;
                        r_addr[i] <= '0;
                        r_rem[i]  <= '0;
                    end else if (flush) begin
                        r_vld[i]  <= 1'b0;
                    end else if (!stop) begin
                        r_vld[i]  <= r_vld[i-1];
                        r_addr[i] <= r_addr[i-1];
                        r_rem[i]  <= (r_rem[i-1] == '0) ? '0 : r_rem[i-1] - LAT_W'(1);
                    end
                end
            end
            assign w_win_vld[i]                   = r_vld[i];
            assign w_win_addr[i*REG_AW +: REG_AW] = r_addr[i];
            assign w_win_rem[i*LAT_W +: LAT_W]    = r_rem[i];
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_port
            hazard_sb_match #(
                .REG_AW (REG_AW),
                .DEPTH  (DEPTH),
                .LAT_W  (LAT_W)
            ) u_match (
                .rd_en     (rd_en[p]),
                .rd_addr   (rd_addr[p*REG_AW +: REG_AW]),
                .win_vld   (w_win_vld),
                .win_addr  (w_win_addr),
                .win_rem   (w_win_rem),
                .hit       (w_hit[p]),
                .hit_ready (w_hit_ready[p])
            );
            // With forwarding a ready youngest producer is bypassed, so only pending ones stall.
            assign hz_port[p] = (FWD_EN != 0) ? (w_hit[p] & ~w_hit_ready[p]) : w_hit[p];
        end
    endgenerate

    assign bbl = (stop || (|hz_port)) ? c_bbl_enable : c_bbl_disable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!stop && (|hz_port) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_sb.md
# hazard_sb

Parametrised hazard scoreboard for the in-order MIPS pipeline. It records the destination of each issued instruction over a DEPTH-entry in-flight window and tracks how many cycles remain before each result can be forwarded. It compares NUM_RD decode-stage source operands against that window and asserts a bubble request when an operand is not yet available. Supports a full-interlock mode and a forwarding-aware mode, plus flush and a saturating stall counter.

## Interface
- NUM_RD, 2, number of source-operand read ports checked per cycle
- REG_AW, 5, register address width; address 0 is the NOP register and is never hazardous
- DEPTH, 3, in-flight window; an entry retires to the register file after DEPTH advances
- FWD_EN, 1, 1 = stall only while the youngest matching result is not yet ready; 0 = stall on any matching in-flight entry
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- stop  in  1  external freeze: window holds and bbl is forced to 1
- flush  in  1  invalidates all window entries
- rd_en  in  NUM_RD  per-port read valid
- rd_addr  in  NUM_RD*REG_AW  port p at bits [p*REG_AW +: REG_AW]
- wr_en  in  1  decode-stage instruction writes a register
- wr_addr  in  REG_AW  its destination
- wr_lat  in  LAT_W=$clog2(DEPTH+1)  advances until its result is forwardable; 0 = forwardable next cycle
- bbl  out  1  bubble request to decode and fetch
- hz_port  out  NUM_RD  per-port hazard flags
- stall_cnt  out  CNT_W  count of hazard-caused bubble cycles

## Operation
- Entry i (0 = youngest) holds valid, addr, and rem (a countdown of LAT_W bits).
- Port p hazard: rd_en[p], rd_addr_p != 0, and a valid entry with addr == rd_addr_p exists.
  - FWD_EN=1: only the youngest such entry is considered, and the hazard is raised if its rem != 0. Older matches are shadowed.
  - FWD_EN=0: any match raises the hazard.
- bbl = stop | (|hz_port). hz_port is raw per port and is not masked by stop.
- Advance happens when !stop.
  - Entry i takes entry i-1, with rem decremented and saturating at 0.
  - The oldest entry is discarded. The register file is write-through, so retired results are visible.
  - Entry 0 is loaded from wr_addr/wr_lat when wr_en & !bbl & wr_addr != 0. Otherwise entry 0 loads invalid (bubble).
  - wr_lat > DEPTH is clamped to DEPTH.
- Hold happens when stop: all entries are unchanged, including rem.
- flush clears every valid bit on the clock edge. It overrides both advance and stop. The issuing instruction is not recorded.
- stall_cnt increments when !stop & |hz_port and saturates at all-ones. It holds otherwise, and flush does not clear it.

## Timing
- hz_port and bbl are combinational from the current window and rd_*. There is no added latency, and both are valid in the same cycle as the operands.
- A producer with wr_lat = L issued at edge t stops causing hazards (FWD_EN=1) after L further advances. stop cycles do not count as advances.
- FWD_EN=0: a producer causes hazards for exactly DEPTH advances.
- While rst is high: all entries are invalid, stall_cnt = 0, hz_port = 0, and bbl = stop.
- Reset mid-operation discards every in-flight entry immediately, without waiting for a clock edge.

## Structure
- Use the shared defines for `NOPRegAddr`, `BblEnable`, `BblDisable` and `RegAddrBus`. LAT_W is derived locally.
- Sub-module hazard_sb_match, instantiated once per port: a youngest-first priority match over the window that outputs hit and hit_ready.
- The window is a generate-loop shift register. The top level contains the counter and the bbl OR-reduction.

## Test plan
- Defaults, issue wr_addr=8 wr_lat=0, next cycle read port 0 addr 8 → hz_port=00, bbl=0.
- Issue addr=8 wr_lat=2, read addr 8 every cycle → bbl=1 for exactly 2 cycles, then 0; stall_cnt=2.
- Issue addr=8 lat=2, then addr=8 lat=0, then read 8 → no hazard, because the younger ready entry shadows the older one. With FWD_EN=0 → bbl=1 until both retire (3 advances each).
- Issue addr=9 lat=3, assert stop for 4 cycles, then release → bbl=1 throughout stop; the hazard persists for 3 advances after release; stall_cnt excludes the stop cycles.
- Issue addr=9 lat=3, flush next edge, read 9 → bbl=0; a read of addr 0 with rd_en=1 never hazards.
- rst pulsed asynchronously mid-hazard → entries clear and bbl drops without a clock edge; stall_cnt=0. Also drive CNT_W=2 with 5 hazard cycles → stall_cnt saturates at 3.
